// File: rtl/sort_stream_seq_pkg.sv
// Shared definitions for the streaming insertion sorter and the combinational sorter tests.
// Holds FSM state codes, sort-direction codes and the default element type.
package sort_pkg;

    localparam int ELEM_W = 4;

    typedef logic [ELEM_W-1:0] elem_t;

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/sort_stream_seq_if.sv
// Valid/ready stream bundle for sort_stream_seq: serial input side plus sorted output side.
// master = producer/consumer environment, slave = the sorter.
interface sort_stream_seq_if #(
    parameter int W = 4
);

    logic         dir;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output dir,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  dir,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/sort_stream_seq_slot.sv
// One element slot of the insertion array: value register, occupied flag and the
// per-slot compare that decides hold / take new / shift up / shift down.
module sort_insert_slot
    import sort_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         insert_en,
    input  logic         shift_en,
    input  logic         dir,
    input  logic         prev_occ,
    input  logic         prev_prec,
    input  logic [W-1:0] new_data,
    input  logic [W-1:0] lower_val,
    input  logic [W-1:0] upper_val,
    output logic [W-1:0] val,
    output logic         occ,
    output logic         prec
);

    logic [W-1:0] val_q, val_d;
    logic         occ_q, occ_d;

    always_comb begin
        // Non-strict compare keeps equal values in arrival order.
        prec  = occ_q && ((dir == DIR_DESC) ? (val_q >= new_data) : (val_q <= new_data));
        val_d = val_q;
        occ_d = occ_q;
        if (shift_en) begin
            val_d = upper_val;
            occ_d = 1'b0;
        end else if (insert_en) begin
            occ_d = occ_q | prev_occ;
            if (!prev_prec) begin
                val_d = lower_val;
            end else if (!prec) begin
                val_d = new_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            occ_q <= 1'b0;
        end else begin
            val_q <= val_d;
            occ_q <= occ_d;
        end
    end

    assign val = val_q;
    assign occ = occ_q;

endmodule

// File: rtl/sort_stream_seq.sv
// Streaming insertion sorter: loads N elements serially, keeping the array sorted on
// every accept, then drains the sorted frame serially from slot 0.
module sort_stream_seq
    import sort_pkg::*;
#(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_stream_seq_if.slave  bus
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic          dir_q, dir_d;

    logic          in_hs;
    logic          out_hs;
    logic          dir_eff;

    logic [W-1:0]  slot_val   [N];
    logic          slot_occ   [N];
    logic          slot_prec  [N];
    logic [W-1:0]  lower_val  [N];
    logic [W-1:0]  upper_val  [N];
    logic          prev_occ   [N];
    logic          prev_prec  [N];
    logic          unused_tail;

    assign in_hs  = bus.in_valid  && (state_q == ST_LOAD);
    assign out_hs = bus.out_ready && (state_q == ST_DRAIN);

    // The first element of a frame is compared under the freshly presented dir.
    assign dir_eff = (load_cnt_q == '0) ? bus.dir : dir_q;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        dir_d       = dir_q;
        case (state_q)
            ST_LOAD: begin
                if (in_hs) begin
                    if (load_cnt_q == '0) begin
                        dir_d = bus.dir;
                    end
                    if (load_cnt_q == LAST_IDX) begin
                        load_cnt_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (out_hs) begin
                    if (drain_cnt_q == LAST_IDX) begin
                        drain_cnt_d = '0;
                        state_d     = ST_LOAD;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
            dir_q       <= DIR_ASC;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            dir_q       <= dir_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign lower_val[k] = '0;
            assign prev_occ[k]  = 1'b1;
            assign prev_prec[k] = 1'b1;
        end else begin : g_body
            assign lower_val[k] = slot_val[k-1];
            assign prev_occ[k]  = slot_occ[k-1];
            assign prev_prec[k] = slot_prec[k-1];
        end
        if (k == N - 1) begin : g_tail
            assign upper_val[k] = '0;
        end else begin : g_nottail
            assign upper_val[k] = slot_val[k+1];
        end

        sort_insert_slot #(
            .W (W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .insert_en (in_hs),
            .shift_en  (out_hs),
            .dir       (dir_eff),
            .prev_occ  (prev_occ[k]),
            .prev_prec (prev_prec[k]),
            .new_data  (bus.in_data),
            .lower_val (lower_val[k]),
            .upper_val (upper_val[k]),
            .val       (slot_val[k]),
            .occ       (slot_occ[k]),
            .prec      (slot_prec[k])
        );
    end

    // The last slot has no successor to feed.
    assign unused_tail = slot_occ[N-1] ^ slot_prec[N-1];

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_data  = (state_q == ST_DRAIN) ? slot_val[0] : '0;
    assign bus.out_last  = (state_q == ST_DRAIN) && (drain_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_sort_stream_seq.sv
// Self-checking bench for sort_stream_seq: fixed vectors plus randomised frames and
// handshakes, checked against a counting-sort reference model.
module tb_sort_stream_seq;

    localparam int N = 10;
    localparam int W = 4;

    typedef logic [W-1:0] frame_t [N];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort_stream_seq_if #(.W(W)) bus ();

    sort_stream_seq #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int assertions = 0;
    int failures   = 0;
    int cycle      = 0;
    int accept_cycle [$];

    always @(posedge clk) cycle <= cycle + 1;

    // Stable sort by value: emit every occurrence of each key in key order.
    function automatic frame_t ref_sort(input frame_t v, input logic d);
        frame_t r;
        int n = 0;
        for (int s = 0; s < (1 << W); s++) begin
            int key = d ? ((1 << W) - 1 - s) : s;
            for (int i = 0; i < N; i++) begin
                if (int'(v[i]) == key) begin
                    r[n] = v[i];
                    n++;
                end
            end
        end
        return r;
    endfunction

    task automatic push_frame(input frame_t vals, input logic d0, input int flip_at,
                              input int vpct, input int count, input string name);
        bit   first = 1'b1;
        logic rdy;
        int   c;
        for (int i = 0; i < count; i++) begin
            bit acc = 1'b0;
            int budget = 0;
            while (!acc) begin
                @(negedge clk);
                if (first) begin
                    assertions++;
                    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL %s load_entry: in_ready=%b out_valid=%b, required 1/0",
                                 name, bus.in_ready, bus.out_valid);
                    end
                    first = 1'b0;
                end
                bus.in_valid  = ($urandom_range(99) < vpct);
                bus.in_data   = bus.in_valid ? vals[i] : W'($urandom);
                bus.dir       = (flip_at >= 0 && i >= flip_at) ? ~d0 : d0;
                bus.out_ready = 1'($urandom_range(1));
                rdy = bus.in_ready;
                c   = cycle;
                @(posedge clk);
                acc = bus.in_valid && rdy;
                if (acc) accept_cycle.push_back(c);
                budget++;
                if (!acc && budget > 200) begin
                    assertions++;
                    failures++;
                    $display("FAIL %s push_timeout: element %0d not accepted", name, i);
                    return;
                end
            end
        end
    endtask

    task automatic drain_frame(input frame_t exp, input int rpct, input int stall_idx,
                               input int count, input string name);
        int           idx = 0;
        int           budget = 0;
        bit           first = 1'b1;
        bit           stalled = 1'b0;
        logic         v, l;
        logic [W-1:0] d;
        while (idx < count) begin
            @(negedge clk);
            if (first) begin
                assertions++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s drain_latency: out_valid=%b in_ready=%b, required 1/0",
                             name, bus.out_valid, bus.in_ready);
                end
                first = 1'b0;
            end
            bus.in_valid = 1'($urandom_range(1));
            bus.in_data  = W'($urandom);
            assertions++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s ready_in_drain: in_ready=%b, required 0", name, bus.in_ready);
            end
            if (idx == stall_idx && !stalled) begin
                stalled = 1'b1;
                bus.out_ready = 1'b0;
                d = bus.out_data;
                l = bus.out_last;
                repeat (5) begin
                    @(negedge clk);
                    assertions++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_last !== l) begin
                        failures++;
                        $display("FAIL %s stall_hold: valid=%b data=%h last=%b, required 1/%h/%b",
                                 name, bus.out_valid, bus.out_data, bus.out_last, d, l);
                    end
                end
            end
            bus.out_ready = ($urandom_range(99) < rpct);
            v = bus.out_valid;
            d = bus.out_data;
            l = bus.out_last;
            @(posedge clk);
            if (v && bus.out_ready) begin
                assertions++;
                if (d !== exp[idx] || l !== logic'(idx == N - 1)) begin
                    failures++;
                    $display("FAIL %s out[%0d]: data=%h last=%b, required %h/%b",
                             name, idx, d, l, exp[idx], logic'(idx == N - 1));
                end
                idx++;
            end
            budget++;
            if (budget > 400) begin
                assertions++;
                failures++;
                $display("FAIL %s drain_timeout: %0d of %0d outputs seen", name, idx, count);
                return;
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        assertions++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_data !== '0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL %s reset_values: in_ready=%b out_valid=%b out_data=%h out_last=%b, required 1/0/0/0",
                     name, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset");
        @(negedge clk);
        assertions++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b out_data=%h, required 1/0/0",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_ascending();
        frame_t f = '{4'h9, 4'h3, 4'h7, 4'h0, 4'hF, 4'h3, 4'h1, 4'h8, 4'h2, 4'h5};
        frame_t e = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h5, 4'h7, 4'h8, 4'h9, 4'hF};
        push_frame(f, 1'b0, -1, 100, N, "asc");
        drain_frame(e, 100, -1, N, "asc");
    endtask

    task automatic test_descending();
        frame_t f = '{4'h9, 4'h3, 4'h7, 4'h0, 4'hF, 4'h3, 4'h1, 4'h8, 4'h2, 4'h5};
        frame_t e = '{4'hF, 4'h9, 4'h8, 4'h7, 4'h5, 4'h3, 4'h3, 4'h2, 4'h1, 4'h0};
        push_frame(f, 1'b1, 3, 100, N, "desc_dirflip");
        drain_frame(e, 100, -1, N, "desc_dirflip");
    endtask

    task automatic test_stability();
        frame_t f6 = '{default: 4'h6};
        frame_t fa = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
        frame_t ea = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        push_frame(f6, 1'b0, -1, 100, N, "all_equal");
        drain_frame(f6, 100, -1, N, "all_equal");
        push_frame(fa, 1'b0, -1, 100, N, "alt_extremes");
        drain_frame(ea, 100, -1, N, "alt_extremes");
    endtask

    task automatic test_backpressure();
        for (int fr = 0; fr < 5; fr++) begin
            frame_t f;
            logic   d = 1'($urandom_range(1));
            for (int i = 0; i < N; i++) f[i] = W'($urandom);
            push_frame(f, d, (fr == 2) ? 5 : -1, 50, N, "backpressure");
            drain_frame(ref_sort(f, d), 50, (fr == 0) ? 4 : -1, N, "backpressure");
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        frame_t g = '{4'h4, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9};
        frame_t e = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h4, 4'h9};
        for (int i = 0; i < N; i++) f[i] = W'($urandom_range(15, 10));
        push_frame(f, 1'b1, -1, 100, 6, "reset_mid_load");
        do_reset("reset_mid_load");
        push_frame(f, 1'b1, -1, 70, N, "reset_mid_drain");
        drain_frame(ref_sort(f, 1'b1), 100, -1, 3, "reset_mid_drain");
        do_reset("reset_mid_drain");
        push_frame(g, 1'b0, -1, 100, N, "after_reset");
        drain_frame(e, 100, -1, N, "after_reset");
    endtask

    task automatic test_back_to_back();
        accept_cycle.delete();
        for (int fr = 0; fr < 3; fr++) begin
            frame_t f;
            logic   d = logic'(fr % 2);
            for (int i = 0; i < N; i++) f[i] = W'($urandom);
            push_frame(f, d, -1, 100, N, "back_to_back");
            drain_frame(ref_sort(f, d), 100, -1, N, "back_to_back");
        end
        for (int fr = 1; fr < 3; fr++) begin
            assertions++;
            if (accept_cycle.size() < 3 * N ||
                accept_cycle[fr * N] - accept_cycle[(fr - 1) * N] != 2 * N) begin
                failures++;
                $display("FAIL back_to_back period: frame %0d start delta wrong (accepts=%0d), required %0d cycles",
                         fr, accept_cycle.size(), 2 * N);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.dir       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_ascending();
        test_descending();
        test_stability();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/sort_stream_seq.md
Name: sort_stream_seq

Overview:
- Streaming counterpart of the combinational N-element sorter network.
- Accepts a frame of exactly N W-bit elements serially over a valid/ready input, sorting each element into place as it arrives (insertion sort).
- Drains the sorted frame serially over a valid/ready output.
- Sits between serial producers/consumers and the sorting datapath; ascending or descending order is selected per frame.

Parameters:
- N, 10, elements per frame; N >= 2.
- W, 4, element width in bits.
- CW, $clog2(N+1), internal counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dir  input  1  sort order, 0 = ascending, 1 = descending; sampled with the first element of each frame.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block accepts an element (high only in LOAD).
- in_data  input  W  element value, unsigned.
- out_valid  output  1  out_data holds a sorted element (high only in DRAIN).
- out_ready  input  1  downstream accepts out_data.
- out_data  output  W  current sorted element, first-in-order first.
- out_last  output  1  high with the final (Nth) element of the drained frame.

Behaviour:
- States:
  - LOAD: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
- Reset (async assert, sync release) puts the block in LOAD and clears all state:
  - load count = 0, drain count = 0, dir_q = 0, element array all zero.
  - Outputs: in_ready=1 once in LOAD, out_valid=0, out_data=0, out_last=0.
- A handshake is valid & ready on the same rising edge; no other event changes state.
- LOAD, on each input handshake:
  - If load count == 0, latch dir into dir_q first; the insertion compare uses the new dir value that same cycle.
  - Insert in_data into array slots [0..N-1] in one cycle. Every slot k where "slot precedes new" holds keeps its value; the first non-preceding slot takes in_data; later slots shift up by one.
  - Ascending: "precedes" means slot <= new. Descending: slot >= new. Equal values therefore keep arrival order (stable).
  - Only slots [0..count-1] are considered occupied. Unoccupied slots never precede.
  - Increment load count. On the Nth handshake (count == N-1), go to DRAIN with load count cleared.
- DRAIN:
  - out_data = slot[0] (registered, no combinational path from inputs).
  - out_last = 1 when drain count == N-1.
  - On each output handshake, shift array down by one, fill slot[N-1] with 0, and increment drain count.
  - On the handshake with out_last=1, go to LOAD with drain count cleared.
- Latency:
  - out_valid rises the cycle after the Nth input handshake.
  - in_ready rises the cycle after the last output handshake.
  - Minimum frame period is 2N cycles with no stalls.
- Backpressure: out_ready low holds out_data and out_last stable. in_valid low simply pauses LOAD; there is no timeout.
- dir changes mid-frame are ignored until the next frame's first element.
- in_valid during DRAIN is ignored (in_ready=0) and no data is dropped. out_ready during LOAD is ignored.
- Reset mid-frame discards the partial frame; the next frame starts clean.
- No partial frames: fewer than N elements never produce output.

Decomposition:
- Shared package sort_pkg:
  - state encoding (ST_LOAD, ST_DRAIN)
  - DIR_ASC=1'b0, DIR_DESC=1'b1
  - element type of width W (for reuse by the combinational sorter tests)
- One natural sub-module, sort_insert_slot, instantiated N times in a generate loop. Each slot holds one W-bit register plus its occupied flag. It computes its "precedes" bit and selects among hold / take new / take lower neighbour / take upper neighbour (drain shift).
- The top level keeps the FSM, counters and dir_q. The insert position is the first slot whose predecessor precedes and whose own value does not.

Test Plan:
- Ascending, no stalls, N=10: dir=0, inputs 9,3,7,0,F,3,1,8,2,5 -> outputs 0,1,2,3,3,5,7,8,9,F. out_valid rises the cycle after the 10th accept; out_last only on F; in_ready returns the cycle after.
- Descending, same inputs with dir=1 -> F,9,8,7,5,3,3,2,1,0. Toggle dir to 0 after element 3 -> order unchanged.
- Stability and extremes: all elements equal 6, then alternating 0/F with dir=0 -> ten 6s, then five 0s and five Fs. A tagged-duplicate model confirms arrival order.
- Backpressure: randomise in_valid and out_ready at 50%. Hold out_ready=0 for 5 cycles on element 4 -> out_data and out_last stable. Every frame matches the reference sort model; in_valid during DRAIN is never accepted.
- Reset mid-operation: assert rst_n=0 after 6 inputs, and again after 3 outputs of a later frame -> outputs go to reset values immediately. The next full frame 4,4,2,1,0,0,0,0,0,9 (asc) drains as 0,0,0,0,0,1,2,4,4,9.
- Back-to-back frames: 3 consecutive frames with alternating dir -> each correctly sorted, 2N-cycle period when unstalled.
